// File: rtl/stump_pkg.sv
// Shared Stump datapath constants.
// Register indices, flag bit positions and word width.
package stump_pkg;

  localparam int WIDTH = 16;

  localparam logic [2:0] REG_ZERO = 3'd0;
  localparam logic [2:0] REG_PC   = 3'd7;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_V = 1;
  localparam int CC_C = 0;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [3:0]       nzvc_t;

endpackage

// File: rtl/stump_read_mux.sv
// Flat 8:1 register read mux.
// Address 0 is forced to zero; R0 has no storage.
module stump_read_mux
  import stump_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [7:1][W-1:0] regs,
  input  logic [2:0]        addr,
  output logic [W-1:0]      data
);

  always_comb begin
    data = '0;
    case (addr)
      3'd1:    data = regs[1];
      3'd2:    data = regs[2];
      3'd3:    data = regs[3];
      3'd4:    data = regs[4];
      3'd5:    data = regs[5];
      3'd6:    data = regs[6];
      3'd7:    data = regs[7];
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/stump_reg_bank.sv
// Stump architectural state: R1-R7 (R7 = PC) and NZVC.
// Writeback overrides the fetch increment on R7.
module stump_reg_bank
  import stump_pkg::*;
#(
  parameter int WIDTH = stump_pkg::WIDTH,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] pc,
  input  logic             cc_en,
  input  logic [3:0]       cc_in,
  output logic [3:0]       cc,
  output logic             c_flag,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [7:1][WIDTH-1:0] rf;
  logic [3:0]            cc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf   <= '0;
      cc_q <= '0;
    end else begin
      if (pc_inc)
        rf[7] <= rf[7] + WIDTH'(1);
      // later assignment wins, so a write to R7 beats fetch
      for (int i = 1; i < NREGS; i++)
        if (wr_en && wr_addr == 3'(i))
          rf[i] <= wr_data;
      if (cc_en)
        cc_q <= cc_in;
    end
  end

  assign pc     = rf[REG_PC];
  assign cc     = cc_q;
  assign c_flag = cc_q[CC_C];

  stump_read_mux #(.W(WIDTH)) u_mux_a (
    .regs (rf),
    .addr (rd_addr_a),
    .data (rd_data_a)
  );

  stump_read_mux #(.W(WIDTH)) u_mux_b (
    .regs (rf),
    .addr (rd_addr_b),
    .data (rd_data_b)
  );

  stump_read_mux #(.W(WIDTH)) u_mux_d (
    .regs (rf),
    .addr (dbg_addr),
    .data (dbg_data)
  );

endmodule

// File: tb/tb_stump_reg_bank.sv
// Scoreboard bench for stump_reg_bank.
// Expected values queued at stimulus time, popped at sample time.
module tb_stump_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        pc_inc;
  logic [15:0] pc;
  logic        cc_en;
  logic [3:0]  cc_in;
  logic [3:0]  cc;
  logic        c_flag;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] ex;

  stump_reg_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pc_inc    (pc_inc),
    .pc        (pc),
    .cc_en     (cc_en),
    .cc_in     (cc_in),
    .cc        (cc),
    .c_flag    (c_flag),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    pc_inc = 1'b0;
    cc_en  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hFFFF;
    pc_inc = 1'b1; cc_en = 1'b1; cc_in = 4'hF;
    rd_addr_a = 3'd1;
    sb.push_back(16'h0000);
    sb.push_back(16'h0000);
    sb.push_back(16'h0000);
    tick();
    tick();
    ex = sb.pop_front(); checks++;
    if (pc !== ex) begin
      errors++; $display("FAIL rst_hold_pc got %h want %h", pc, ex);
    end
    ex = sb.pop_front(); checks++;
    if ({12'h0, cc} !== ex) begin
      errors++; $display("FAIL rst_hold_cc got %h want %h", cc, ex);
    end
    ex = sb.pop_front(); checks++;
    if (rd_data_a !== ex) begin
      errors++; $display("FAIL rst_hold_r1 got %h want %h", rd_data_a, ex);
    end
    idle();
    rst_n = 1'b1;
    tick();
    wr(3'd3, 16'h1234);
    wr(3'd7, 16'h0055);
    cc_en = 1'b1; cc_in = 4'hF;
    tick();
    idle();
    rd_addr_a = 3'd3;
    sb.push_back(16'h1234);
    #1;
    ex = sb.pop_front(); checks++;
    if (rd_data_a !== ex) begin
      errors++; $display("FAIL load_r3 got %h want %h", rd_data_a, ex);
    end
    #1 rst_n = 1'b0;
    sb.push_back(16'h0000);
    sb.push_back(16'h0000);
    sb.push_back(16'h0000);
    sb.push_back(16'h0000);
    #1;
    ex = sb.pop_front(); checks++;
    if (rd_data_a !== ex) begin
      errors++; $display("FAIL async_rst_r3 got %h want %h", rd_data_a, ex);
    end
    ex = sb.pop_front(); checks++;
    if (pc !== ex) begin
      errors++; $display("FAIL async_rst_pc got %h want %h", pc, ex);
    end
    ex = sb.pop_front(); checks++;
    if ({12'h0, cc} !== ex) begin
      errors++; $display("FAIL async_rst_cc got %h want %h", cc, ex);
    end
    ex = sb.pop_front(); checks++;
    if ({15'h0, c_flag} !== ex) begin
      errors++; $display("FAIL async_rst_c got %h want %h", c_flag, ex);
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_r0();
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    sb.push_back(16'h0000);
    sb.push_back(16'h0000);
    wr(3'd0, 16'hBEEF);
    ex = sb.pop_front(); checks++;
    if (rd_data_a !== ex) begin
      errors++; $display("FAIL r0_a got %h want %h", rd_data_a, ex);
    end
    ex = sb.pop_front(); checks++;
    if (rd_data_b !== ex) begin
      errors++; $display("FAIL r0_b got %h want %h", rd_data_b, ex);
    end
  endtask

  task automatic test_pc();
    wr(3'd7, 16'hFFFF);
    pc_inc = 1'b1;
    sb.push_back(16'h0000);
    tick();
    ex = sb.pop_front(); checks++;
    if (pc !== ex) begin
      errors++; $display("FAIL pc_wrap got %h want %h", pc, ex);
    end
    pc_inc = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h0040;
    sb.push_back(16'h0040);
    tick();
    idle();
    ex = sb.pop_front(); checks++;
    if (pc !== ex) begin
      errors++; $display("FAIL pc_prio got %h want %h", pc, ex);
    end
  endtask

  task automatic test_rdw();
    wr(3'd5, 16'h0001);
    rd_addr_a = 3'd5;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h00FF;
    sb.push_back(16'h0001);
    sb.push_back(16'h00FF);
    #1;
    ex = sb.pop_front(); checks++;
    if (rd_data_a !== ex) begin
      errors++; $display("FAIL rdw_pre got %h want %h", rd_data_a, ex);
    end
    tick();
    idle();
    ex = sb.pop_front(); checks++;
    if (rd_data_a !== ex) begin
      errors++; $display("FAIL rdw_post got %h want %h", rd_data_a, ex);
    end
  endtask

  task automatic test_flags();
    rd_addr_a = 3'd5;
    rd_addr_b = 3'd0;
    cc_en = 1'b1; cc_in = 4'b0101;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1111;
    sb.push_back(16'h0005);
    sb.push_back(16'h0001);
    sb.push_back(16'h00FF);
    sb.push_back(16'h0000);
    tick();
    idle();
    ex = sb.pop_front(); checks++;
    if ({12'h0, cc} !== ex) begin
      errors++; $display("FAIL cc_load got %h want %h", cc, ex);
    end
    ex = sb.pop_front(); checks++;
    if ({15'h0, c_flag} !== ex) begin
      errors++; $display("FAIL c_flag got %h want %h", c_flag, ex);
    end
    ex = sb.pop_front(); checks++;
    if (rd_data_a !== ex) begin
      errors++; $display("FAIL cc_r5_kept got %h want %h", rd_data_a, ex);
    end
    ex = sb.pop_front(); checks++;
    if (rd_data_b !== ex) begin
      errors++; $display("FAIL cc_r0 got %h want %h", rd_data_b, ex);
    end
    cc_en = 1'b0; cc_in = 4'b0000;
    sb.push_back(16'h0005);
    tick();
    ex = sb.pop_front(); checks++;
    if ({12'h0, cc} !== ex) begin
      errors++; $display("FAIL cc_hold got %h want %h", cc, ex);
    end
  endtask

  task automatic test_concurrent();
    wr(3'd7, 16'h0010);
    dbg_addr = 3'd2;
    rd_addr_b = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hA5A5;
    pc_inc = 1'b1;
    sb.push_back(16'hA5A5);
    sb.push_back(16'hA5A5);
    sb.push_back(16'h0011);
    tick();
    idle();
    ex = sb.pop_front(); checks++;
    if (dbg_data !== ex) begin
      errors++; $display("FAIL conc_dbg got %h want %h", dbg_data, ex);
    end
    ex = sb.pop_front(); checks++;
    if (rd_data_b !== ex) begin
      errors++; $display("FAIL conc_b got %h want %h", rd_data_b, ex);
    end
    ex = sb.pop_front(); checks++;
    if (pc !== ex) begin
      errors++; $display("FAIL conc_pc got %h want %h", pc, ex);
    end
  endtask

  task automatic test_dont_care();
    wr_en = 1'b0; wr_addr = 'x; wr_data = 'x;
    sb.push_back(16'hA5A5);
    sb.push_back(16'h0011);
    tick();
    ex = sb.pop_front(); checks++;
    if (dbg_data !== ex) begin
      errors++; $display("FAIL dc_r2 got %h want %h", dbg_data, ex);
    end
    ex = sb.pop_front(); checks++;
    if (pc !== ex) begin
      errors++; $display("FAIL dc_pc got %h want %h", pc, ex);
    end
    wr_addr = 3'd0; wr_data = 16'h0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] m [8];
    logic [2:0]  ra;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m[i] = 16'h0;
    for (int n = 0; n < 40; n++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 16'($urandom);
      pc_inc  = 1'($urandom_range(0, 1));
      ra      = 3'($urandom_range(0, 7));
      dbg_addr = ra;
      if (pc_inc) m[7] = m[7] + 16'd1;
      if (wr_en && wr_addr != 3'd0) m[wr_addr] = wr_data;
      sb.push_back(m[ra]);
      tick();
      ex = sb.pop_front(); checks++;
      if (dbg_data !== ex) begin
        errors++;
        $display("FAIL b2b_r%0d got %h want %h", ra, dbg_data, ex);
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0; dbg_addr = 3'd0;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0;
    pc_inc = 1'b0; cc_en = 1'b0; cc_in = 4'h0;
    #2;
    test_reset();
    test_r0();
    test_pc();
    test_rdw();
    test_flags();
    test_concurrent();
    test_dont_care();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
